muldiv_seq: RTL
===============

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter: CNT_W, default 6, iteration counter width; SHALL hold the value WIDTH.
REQ-003 clk  input  1  Pipeline clock; all state changes on its rising edge.
REQ-004 reset  input  1  Synchronous, active-high reset.
REQ-005 i_start  input  1  EX-stage request to begin a multi-cycle op; sampled only in IDLE.
REQ-006 i_op  input  2  Operation select: 00 MUL (low WIDTH bits), 01 DIVU (quotient), 10 REMU (remainder), 11 reserved, treated as MUL.
REQ-007 i_Op1  input  WIDTH  Forwarded ALU operand 1: multiplicand or dividend.
REQ-008 i_Op2  input  WIDTH  Forwarded ALU operand 2: multiplier or divisor.
REQ-009 i_Rds_addr  input  5  Destination register of the requesting instruction.
REQ-010 i_flush  input  1  Branch-unit kill of the in-flight op.
REQ-011 o_stall  output  1  Drives the IFID, IDEX and EXMA stall inputs.
REQ-012 o_busy  output  1  High in RUN.
REQ-013 o_done  output  1  One-cycle pulse; o_result and o_Rds_addr are valid in that cycle.
REQ-014 o_result  output  WIDTH  Selected result.
REQ-015 o_Rds_addr  output  5  Latched destination register.

Function
REQ-016 The sequencer SHALL implement the states IDLE, RUN and DONE, encoded in 2 bits.
REQ-017 In IDLE with i_start=1 and i_flush=0, the sequencer SHALL latch the operands, i_op and i_Rds_addr, clear the accumulator, load the counter with WIDTH, and move to RUN.
REQ-018 If the op is DIVU or REMU with i_Op2=0, the sequencer SHALL skip RUN and move directly to DONE, with quotient = all-ones and remainder = i_Op1.
REQ-019 MUL in RUN: each cycle, if multiplier bit0=1 the accumulator SHALL add the multiplicand; the multiplicand SHALL shift left and the multiplier SHALL shift right; only the low WIDTH bits are kept, and overflow is discarded.
REQ-020 DIVU/REMU in RUN: restoring division, one quotient bit per cycle, MSB first; the remainder register is WIDTH+1 bits wide, and the trial subtract SHALL use the unsigned borrow.
REQ-021 The counter SHALL decrement once per RUN cycle; when the counter equals 1 and no flush is present, the next state SHALL be DONE, giving exactly WIDTH cycles in RUN.
REQ-022 DONE SHALL last exactly one cycle, with o_done=1, and then return to IDLE.
REQ-023 Latency: i_start accepted at edge t SHALL produce o_done high during cycle t+WIDTH+1 (cycle 33 for WIDTH=32); for divide-by-zero, o_done SHALL be high during cycle t+1.
REQ-024 o_stall SHALL equal (IDLE and i_start and not i_flush) or RUN; it is combinational so the requesting instruction holds in EX on its first cycle.
REQ-025 o_stall SHALL be low in DONE so the pipeline advances and captures o_result.
REQ-026 i_start SHALL be ignored in RUN and DONE, with no relatch and no queuing.
REQ-027 i_flush in RUN SHALL force IDLE at the next edge, with no o_done pulse; i_flush in IDLE SHALL block acceptance; i_flush in DONE SHALL be ignored, since the result is already committed.
REQ-028 When i_flush and counter=1 occur in the same cycle, flush SHALL win: the next state is IDLE and no o_done pulse is produced.
REQ-029 o_result and o_Rds_addr SHALL hold their last DONE value until the next DONE.
REQ-030 The sequencer SHALL never produce an X output after reset, including for i_op=11.

Reset
REQ-031 reset=1 SHALL, at the next edge, set state=IDLE, counter=0, o_stall=0, o_busy=0, o_done=0, o_result=0 and o_Rds_addr=0, in any state.
REQ-032 Reset SHALL take priority over i_start and i_flush; reset during RUN SHALL abandon the op with no o_done pulse.
REQ-033 While reset=1, o_stall SHALL be 0 regardless of i_start.

Verification
REQ-034 MUL, i_Op1=7, i_Op2=6 -> o_stall high in cycles t..t+32, o_done in cycle t+33, o_result=42.
REQ-035 MUL, 0xFFFFFFFF × 0xFFFFFFFF -> o_result=0x00000001; DIVU 100/7 -> o_result=14; REMU 100/7 -> o_result=2; both with 33-cycle latency.
REQ-036 DIVU, i_Op1=0x1234, i_Op2=0 -> o_done at t+1, o_result=0xFFFFFFFF; REMU with the same operands -> o_result=0x1234.
REQ-037 i_flush asserted at RUN iteration 10 -> IDLE next cycle, o_stall low, no o_done; a fresh i_start is accepted immediately after.
REQ-038 i_start toggled during RUN with new operands -> original result unchanged, exactly one o_done.
REQ-039 reset pulsed at iteration 20 -> all outputs 0 next cycle, no o_done; a subsequent MUL 3×5 yields 15.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the EX stage and the multi-cycle multiply/divide sequencer.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
) ();
  logic             i_start;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_Op1;
  logic [WIDTH-1:0] i_Op2;
  logic [4:0]       i_Rds_addr;
  logic             i_flush;
  logic             o_stall;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_result;
  logic [4:0]       o_Rds_addr;

  modport master (
    output i_start, i_op, i_Op1, i_Op2, i_Rds_addr, i_flush,
    input  o_stall, o_busy, o_done, o_result, o_Rds_addr
  );

  modport slave (
    input  i_start, i_op, i_Op1, i_Op2, i_Rds_addr, i_flush,
    output o_stall, o_busy, o_done, o_result, o_Rds_addr
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle,
// sequenced IDLE -> RUN (WIDTH cycles) -> DONE with a pipeline stall output.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        reset,
  muldiv_seq_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;    // multiplicand, or divisor
  logic [WIDTH-1:0] mplier_q, mplier_d;  // multiplier, or dividend shifting into quotient
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       rds_out_q, rds_out_d;
  logic             accept;
  logic             div_in;

  // One restoring-division step: returns {remainder, quotient}.
  function automatic logic [2*WIDTH:0] div_step(input logic [WIDTH:0]   rem,
                                                input logic [WIDTH-1:0] quo,
                                                input logic [WIDTH-1:0] dvsr);
    logic [WIDTH+1:0] sh;
    logic [WIDTH+1:0] diff;
    sh   = {rem, quo[WIDTH-1]};
    diff = sh - {2'b00, dvsr};
    if (diff[WIDTH+1]) begin
      return {sh[WIDTH:0], quo[WIDTH-2:0], 1'b0};
    end
    return {diff[WIDTH:0], quo[WIDTH-2:0], 1'b1};
  endfunction

  assign accept = (state_q == S_IDLE) && bus.i_start && !bus.i_flush;
  assign div_in = (bus.i_op == OP_DIVU) || (bus.i_op == OP_REMU);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    rem_d     = rem_q;
    result_d  = result_q;
    rds_out_d = rds_out_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d     = bus.i_op;
          rd_d     = bus.i_Rds_addr;
          acc_d    = '0;
          mcand_d  = bus.i_Op2;
          mplier_d = bus.i_Op1;
          rem_d    = '0;
          cnt_d    = CNT_W'(WIDTH);
          if (div_in && (bus.i_Op2 == '0)) begin
            state_d   = S_DONE;
            result_d  = (bus.i_op == OP_DIVU) ? '1 : bus.i_Op1;
            rds_out_d = bus.i_Rds_addr;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if ((op_q == OP_DIVU) || (op_q == OP_REMU)) begin
          {rem_d, mplier_d} = div_step(rem_q, mplier_q, mcand_q);
        end else begin
          acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
        // Flush outranks completion, even on the final iteration.
        if (bus.i_flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d   = S_DONE;
          rds_out_d = rd_q;
          case (op_q)
            OP_DIVU: result_d = mplier_d;
            OP_REMU: result_d = rem_d[WIDTH-1:0];
            default: result_d = acc_d;
          endcase
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      result_q  <= '0;
      rds_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      result_q  <= result_d;
      rds_out_q <= rds_out_d;
    end
  end

  always_ff @(posedge clk) begin
    rd_q     <= rd_d;
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    rem_q    <= rem_d;
  end

  // Stall is combinational so the requester holds in EX on its accept cycle.
  assign bus.o_stall    = !reset && (accept || (state_q == S_RUN));
  assign bus.o_busy     = (state_q == S_RUN);
  assign bus.o_done     = (state_q == S_DONE);
  assign bus.o_result   = result_q;
  assign bus.o_Rds_addr = rds_out_q;
endmodule
